// File: rtl/video_pkg.sv
`default_nettype none
// video_pkg: shared frame constants, pixel width and downscaler FSM states. Rev 1.0
package video_pkg;
  localparam int SRC_W_DEF = 320;
  localparam int SRC_H_DEF = 240;
  localparam int DST_W     = 160;
  localparam int DST_H     = 120;
  localparam int PIX_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/rd_pipe_tag.sv
`default_nettype none
// rd_pipe_tag: DEPTH-stage tag delay line travelling alongside source reads. Rev 1.0
module rd_pipe_tag #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/ram_downscale.sv
`default_nettype none
// ram_downscale: SRC_W x SRC_H -> half-resolution frame copier. Rev 1.0
// DOWNSCALE_AVG_EN selects the 2x2 rounded average; otherwise top-left decimation.
module ram_downscale
  import video_pkg::*;
#(
  parameter int SRC_W    = SRC_W_DEF,
  parameter int SRC_H    = SRC_H_DEF,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int DST_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] src_rdaddr,
  input  logic [PIX_W-1:0]  src_q,
  output logic [ADDR_W-1:0] dst_wraddr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_wren,
  output logic              busy,
  output logic              done
);
  localparam int OW    = SRC_W / 2;
  localparam int OH    = SRC_H / 2;
  localparam int XW    = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW    = (OH > 1) ? $clog2(OH) : 1;
  localparam int TAG_W = ADDR_W + 2;

  state_t            state, state_nx;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic [ADDR_W-1:0] rd_base, dst_nxt, rd_addr_nx;
  logic [1:0]        dcnt;
  logic              scan_end, issue, blk_last, frame_last;
  logic [TAG_W-1:0]  tag_out;
  logic              t_valid, t_last;
  logic [ADDR_W-1:0] t_addr;
  logic [PIX_W-1:0]  px;

`ifdef DOWNSCALE_AVG_EN
  logic [1:0] sub;
  assign blk_last   = (sub == 2'd3);
  assign rd_addr_nx = rd_base + (sub[1] ? ADDR_W'(SRC_W) : '0) + ADDR_W'(sub[0]);
`else
  assign blk_last   = 1'b1;
  assign rd_addr_nx = rd_base;
`endif
  assign frame_last = blk_last && (ox == XW'(OW-1)) && (oy == YW'(OH-1));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE:  if (start) begin
                  state_nx = ST_READ;
                  issue    = 1'b1;
                end
      ST_READ:  if (scan_end) state_nx = ST_DRAIN;
                else          issue    = 1'b1;
      ST_DRAIN: if (dcnt == 2'(RD_LAT-1)) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Scan counters hold the address for the next issue; cleared whenever idle so a start begins at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      scan_end   <= 1'b0;
      src_rdaddr <= '0;
      dcnt       <= '0;
      ox         <= '0;
      oy         <= '0;
      rd_base    <= '0;
      dst_nxt    <= ADDR_W'(DST_BASE);
`ifdef DOWNSCALE_AVG_EN
      sub        <= '0;
`endif
    end else begin
      state      <= state_nx;
      scan_end   <= issue && frame_last;
      src_rdaddr <= issue ? rd_addr_nx : '0;
      dcnt       <= (state == ST_DRAIN) ? dcnt + 2'd1 : 2'd0;
      if (issue) begin
`ifdef DOWNSCALE_AVG_EN
        sub <= sub + 2'd1;
`endif
        if (blk_last) begin
          dst_nxt <= dst_nxt + ADDR_W'(1);
          if (ox == XW'(OW-1)) begin
            ox      <= '0;
            oy      <= oy + YW'(1);
            rd_base <= rd_base + ADDR_W'(SRC_W + 2);
          end else begin
            ox      <= ox + XW'(1);
            rd_base <= rd_base + ADDR_W'(2);
          end
        end
      end else begin
        ox      <= '0;
        oy      <= '0;
        rd_base <= '0;
        dst_nxt <= ADDR_W'(DST_BASE);
`ifdef DOWNSCALE_AVG_EN
        sub     <= '0;
`endif
      end
    end
  end

  rd_pipe_tag #(.DEPTH(RD_LAT), .W(TAG_W)) u_tag (
    .clk  (clk),
    .reset(reset),
    .din  ({issue, blk_last, dst_nxt}),
    .dout (tag_out)
  );
  assign {t_valid, t_last, t_addr} = tag_out;

`ifdef DOWNSCALE_AVG_EN
  logic [9:0] acc, sum;
  assign sum = acc + {2'b00, src_q};
  assign px  = PIX_W'((sum + 10'd2) >> 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       acc <= '0;
    else if (t_valid) acc <= t_last ? '0 : sum;
  end
`else
  assign px = src_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_wren   <= 1'b0;
      dst_wraddr <= '0;
      dst_data   <= '0;
    end else begin
      dst_wren   <= t_valid && t_last;
      dst_wraddr <= (t_valid && t_last) ? t_addr : '0;
      dst_data   <= (t_valid && t_last) ? px : '0;
    end
  end

  assign busy = (state == ST_READ) || (state == ST_DRAIN);
  assign done = (state == ST_FIN);
endmodule
`default_nettype wire

// File: doc/ram_downscale.md
# ram_downscale

Frame reducer that reads the 320x240 upscaled framebuffer through its read port and writes a 160x120 half-resolution copy into a destination RAM. Each output pixel is the rounded average of a 2x2 source block; with averaging compiled out, it is the top-left sample of that block. It is the read-side counterpart of the ROM-to-RAM upscaling copier and runs in the 25 MHz VGA clock domain. It drives a `ram2port`-style read address and a write port of a second buffer.

## Interface
- `SRC_W`, 320, source width in pixels (even)
- `SRC_H`, 240, source height in pixels (even)
- `ADDR_W`, 19, address width for both RAMs
- `RD_LAT`, 1, source RAM read latency in cycles (address in -> `src_q` valid), 1..3
- `DST_BASE`, 0, destination address of output pixel (0,0)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `src_rdaddr`  out  ADDR_W  source read address
- `src_q`  in  8  source read data (8-bit grayscale intensity)
- `dst_wraddr`  out  ADDR_W  destination write address
- `dst_data`  out  8  destination write data
- `dst_wren`  out  1  destination write strobe, one cycle per output pixel
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse after the last write

## Operation
- Reset: all outputs 0, FSM in IDLE. Reset mid-frame stops writes immediately; the partial destination frame is left as is.
- FSM states:
  - IDLE: `start`=1 -> READ.
  - READ: issue one source address per cycle. After the final address -> DRAIN.
  - DRAIN: wait RD_LAT cycles for the data still in flight, then -> FIN.
  - FIN: pulse `done` for one cycle -> IDLE.
- A `start` seen outside IDLE is ignored.
- Output scan is raster order: ox 0..SRC_W/2-1 inner, oy 0..SRC_H/2-1 outer.
- Source read order per output pixel: base=(2·oy)·SRC_W+2·ox, then base+1, base+SRC_W, base+SRC_W+1.
- Arithmetic:
  - 10-bit unsigned accumulator over the 4 samples.
  - Result = (sum+2)>>2, which rounds half up and cannot overflow 8 bits.
  - Accumulator is cleared on the first sample of each block.
- `dst_wraddr` = DST_BASE + oy·(SRC_W/2) + ox. Compute it incrementally; no multiplier.
- `src_rdaddr` is 0 whenever no read is being issued. `dst_wraddr`/`dst_data` are 0 whenever `dst_wren`=0.

## Timing
- Edge E0 samples `start`: `busy` rises and the first address is presented after E0.
- One source address per cycle with no gaps: SRC_W·SRC_H addresses with averaging, SRC_W·SRC_H/4 without.
- Sample for the address presented after edge Ek is captured at edge Ek+RD_LAT.
- `dst_wren` is registered: it is high for one cycle after the edge that captures a block's last sample.
- Throughput: one write per 4 cycles (averaging) or one per cycle (decimation).
- `done` is high for the one cycle after edge E0+N+RD_LAT, where N is the address count. `busy` falls at that same edge.
- Default frame with averaging: N=76800.

## Configuration
- `DOWNSCALE_AVG_EN` defined: 2x2 rounded average, 4 reads per output pixel.
- Undefined:
  - Only base addresses are read, and `dst_data` = sample, unmodified.
  - The accumulator and the intra-block sample counter are removed.
  - The address scan steps by 2 in x and 2·SRC_W in y.

## Structure
- Shared package `video_pkg` holds:
  - frame constants (SRC_W/SRC_H defaults, 160x120 output size);
  - the pixel width (8);
  - the FSM state enum (IDLE, READ, DRAIN, FIN).
- Natural sub-module: `rd_pipe_tag`, a RD_LAT-deep shift register.
  - It carries a valid bit, a last-of-block flag and the destination address alongside each issued read.
  - The write stage aligns to `src_q` from these tags with no separate counters.

## Test plan
- Averaging, source model src[a]=a mod 256, pulse `start`:
  - first write `dst_wraddr`=0, `dst_data`=33 (samples 0,1,64,65);
  - last write `dst_wraddr`=19199 (source addrs 76478, 76479, 76798, 76799);
  - exactly 19200 writes;
  - `done` after edge E0+76801.
- Decimation build, same source: first write data 0; write 1 data 2; write 160 data 128 (src 640); 19200 writes; `done` after edge E0+19201.
- Saturation and rounding:
  - all samples 255 -> every `dst_data`=255;
  - block 0,0,0,2 -> 1;
  - block 0,0,0,1 -> 0.
- `start` held high for 1000 cycles mid-frame -> no restart; write count still 19200; a single `done`.
- `reset` low at cycle 5000 -> next cycle all outputs 0; `busy` 0; a new `start` restarts from `dst_wraddr`=0.
- RD_LAT=3 build with a 3-cycle source model -> same data as the RD_LAT=1 run; `done` 2 cycles later.
